// File: rtl/dp23_gpif_tx.sv
// FIFO-to-FX3 GPIF II burst writer: FX3-watermark-gated bursts with a fixed-latency read pipeline.
// Optional short-packet commit on idle timeout is enabled by defining DP23_GPIF_TX_PKTEND_EN.
module dp23_gpif_tx #(
   parameter int GpifWidth     = 32,
   parameter int BurstLen      = 256,
   parameter int TimeoutCycles = 1024,
   parameter int CntWidth      = 30
) (
   input  logic                 CLK,
   input  logic                 RST,
   output logic                 dpo_rd_o,
   input  logic                 dpo_empty_i,
   input  logic [GpifWidth-1:0] dpo_dto_i,
   input  logic                 gpif_flag_i,
   output logic [GpifWidth-1:0] gpif_data_o,
   output logic                 gpif_wr_n_o,
   output logic                 gpif_pktend_n_o,
   input  logic                 rst_cnt_i,
   output logic [CntWidth-1:0]  words_sent_o,
   output logic [15:0]          pktend_count_o
);

   // state  | meaning
   // IDLE   | wait for FIFO data and FX3 watermark space
   // BURST  | issue FIFO reads, up to BurstLen per burst
   // DRAIN  | reads stopped, let in-flight words reach SLWR
   // GAP    | 4 write-free cycles covering FX3 flag latency
   // PKTEND | one-cycle PKTEND to commit a short packet
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_BURST  = 3'd1,
      S_DRAIN  = 3'd2,
      S_GAP    = 3'd3,
      S_PKTEND = 3'd4
   } state_t;

   localparam int RdW = $clog2(BurstLen + 1);

   state_t           state_q;
   state_t           state_d;
   logic [RdW-1:0]   rd_cnt_q;
   logic [1:0]       gap_cnt_q;
   logic             v1_q;
   logic             v2_q;
   logic             rd;
   logic             burst_full;
   logic             pipe_empty;
   logic [CntWidth-1:0] words_q;

   assign burst_full = (rd_cnt_q == RdW'(BurstLen));
   assign pipe_empty = !v1_q && !v2_q;
   assign dpo_rd_o   = rd && !RST;

`ifdef DP23_GPIF_TX_PKTEND_EN
   localparam int IdW = $clog2(TimeoutCycles + 1);

   logic [IdW-1:0] idle_cnt_q;
   logic [15:0]    pkt_q;

   always_ff @(posedge CLK) begin
      if (RST)
         idle_cnt_q <= '0;
      else if (state_q != S_BURST || rd)
         idle_cnt_q <= '0;
      else
         idle_cnt_q <= idle_cnt_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST || rst_cnt_i)
         pkt_q <= '0;
      else if (state_q == S_PKTEND)
         pkt_q <= pkt_q + 16'd1;
   end

   assign gpif_pktend_n_o = !(state_q == S_PKTEND && !RST);
   assign pktend_count_o  = pkt_q;
`else
   assign gpif_pktend_n_o = 1'b1;
   assign pktend_count_o  = 16'd0;
`endif

   always_comb begin
      state_d = state_q;
      rd      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!dpo_empty_i && gpif_flag_i)
               state_d = S_BURST;
         end
         S_BURST: begin
            rd = !dpo_empty_i && !burst_full;
            if (rd && rd_cnt_q == RdW'(BurstLen - 1))
               state_d = S_DRAIN;
`ifdef DP23_GPIF_TX_PKTEND_EN
            // a timeout before any read just abandons the burst
            else if (!rd && idle_cnt_q == IdW'(TimeoutCycles - 1))
               state_d = (rd_cnt_q == '0) ? S_IDLE : S_DRAIN;
`endif
         end
         S_DRAIN: begin
            if (pipe_empty) begin
`ifdef DP23_GPIF_TX_PKTEND_EN
               state_d = (rd_cnt_q != RdW'(BurstLen)) ? S_PKTEND : S_GAP;
`else
               state_d = S_GAP;
`endif
            end
         end
         S_GAP: begin
            if (gap_cnt_q == 2'd3)
               state_d = S_IDLE;
         end
         S_PKTEND: begin
            state_d = S_GAP;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // v2 lines up with the FIFO data, so the SLWR register fires two cycles after the read is sampled
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         rd_cnt_q    <= '0;
         gap_cnt_q   <= 2'd0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         gpif_wr_n_o <= 1'b1;
         gpif_data_o <= '0;
      end else begin
         state_q     <= state_d;
         v1_q        <= dpo_rd_o;
         v2_q        <= v1_q;
         gpif_wr_n_o <= !v2_q;
         if (v2_q)
            gpif_data_o <= dpo_dto_i;
         if (state_q == S_IDLE)
            rd_cnt_q <= '0;
         else if (rd)
            rd_cnt_q <= rd_cnt_q + 1'b1;
         if (state_q == S_GAP)
            gap_cnt_q <= gap_cnt_q + 2'd1;
         else
            gap_cnt_q <= 2'd0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST || rst_cnt_i)
         words_q <= '0;
      else if (!gpif_wr_n_o)
         words_q <= words_q + 1'b1;
   end

   assign words_sent_o = words_q;

endmodule

// File: tb/tb_dp23_gpif_tx.sv
// Directed bench for dp23_gpif_tx: BurstLen=8, 5-bit word counter so wrap is reachable.
// Follows DP23_GPIF_TX_PKTEND_EN to pick the short-packet or the wait-in-BURST expectations.
module tb_dp23_gpif_tx;
   localparam int W  = 32;
   localparam int BL = 8;
   localparam int TO = 1024;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rd;
   logic          empty = 1'b1;
   logic [W-1:0]  dto = '0;
   logic          flag = 1'b0;
   logic [W-1:0]  data;
   logic          wr_n;
   logic          pktend_n;
   logic          rst_cnt = 1'b0;
   logic [CW-1:0] words;
   logic [15:0]   pkt_cnt;

   dp23_gpif_tx #(
      .GpifWidth(W), .BurstLen(BL), .TimeoutCycles(TO), .CntWidth(CW)
   ) dut (
      .CLK(clk), .RST(rst),
      .dpo_rd_o(rd), .dpo_empty_i(empty), .dpo_dto_i(dto),
      .gpif_flag_i(flag), .gpif_data_o(data), .gpif_wr_n_o(wr_n),
      .gpif_pktend_n_o(pktend_n), .rst_cnt_i(rst_cnt),
      .words_sent_o(words), .pktend_count_o(pkt_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [W-1:0] fifo_q[$];
   logic [W-1:0] sb_q[$];
   logic [W-1:0] p1 = '0;
   logic [W-1:0] p2 = '0;
   int   seq = 0;
   int   cyc = 0;
   int   rd_seen = 0;
   int   wr_seen = 0;
   int   pkt_pulses = 0;
   int   pkt_wide = 0;
   int   rd_empty_viol = 0;
   int   last_wr_cyc = 0;
   int   pkt_cyc = 0;
   int   cur_run = 0;
   logic prev_wr = 1'b0;
   logic prev_pkt = 1'b0;
   int   run_len[$];
   int   run_first[$];
   int   run_last[$];

   // FIFO model: a read seen in cycle c shows its word on dto during cycle c+2
   task automatic tick();
      @(negedge clk);
      if (rd && empty) rd_empty_viol++;
      dto = p2;
      p2  = p1;
      if (rd && fifo_q.size() > 0) begin
         rd_seen++;
         p1 = fifo_q.pop_front();
      end else begin
         if (rd) rd_seen++;
         p1 = 32'hDEAD_BEEF;
      end
      @(posedge clk);
      #1;
      cyc++;
      empty = (fifo_q.size() == 0);
      if (!wr_n) begin
         wr_seen++;
         last_wr_cyc = cyc;
         if (sb_q.size() > 0) chk("slwr_data", data, sb_q.pop_front());
         else chk("slwr_extra", wr_n, 1);
         if (!prev_wr) begin
            cur_run = 0;
            run_first.push_back(cyc);
         end
         cur_run++;
      end else if (prev_wr) begin
         run_len.push_back(cur_run);
         run_last.push_back(cyc - 1);
      end
      prev_wr = !wr_n;
      if (!pktend_n) begin
         pkt_pulses++;
         pkt_cyc = cyc;
         chk("pktend_with_slwr", wr_n, 1);
         if (prev_pkt) pkt_wide++;
      end
      prev_pkt = !pktend_n;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic push(input int n);
      for (int i = 0; i < n; i++) begin
         fifo_q.push_back(32'hC0DE_0000 + W'(seq));
         sb_q.push_back(32'hC0DE_0000 + W'(seq));
         seq++;
      end
      empty = 1'b0;
   endtask

   task automatic clear_runs();
      run_len.delete();
      run_first.delete();
      run_last.delete();
   endtask

   function automatic int run_at(input int i);
      return (i < run_len.size()) ? run_len[i] : -1;
   endfunction

   function automatic int gap_after(input int i);
      return (i + 1 < run_first.size() && i < run_last.size()) ? run_first[i+1] - run_last[i] : -1;
   endfunction

   int n;
   int base;

   initial begin
      run(3);
      chk("rst_rd", rd, 0);
      chk("rst_wr_n", wr_n, 1);
      chk("rst_pktend_n", pktend_n, 1);
      chk("rst_data", data, 0);
      chk("rst_words", words, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      rst = 1'b0;

      // data present but no watermark: nothing moves
      push(8);
      run(20);
      chk("noflag_rd", rd_seen, 0);
      chk("noflag_wr", wr_seen, 0);
      flag = 1'b1;
      n = 0;
      while (wr_seen == 0 && n < 20) begin
         tick();
         n++;
      end
      chk("flag_to_slwr", n - 1, 3);
      run(30);
      chk("b1_words", wr_seen, 8);
      chk("b1_cnt", words, 8);
      chk("data_hold", data, 32'hC0DE_0007);

      // three bursts out of one fill; gap = DRAIN tail + 4 GAP + IDLE + 3-cycle read latency
      clear_runs();
      base = pkt_pulses;
`ifdef DP23_GPIF_TX_PKTEND_EN
      push(20);
      run(1200);
      chk("b2_run0", run_at(0), 8);
      chk("b2_run1", run_at(1), 8);
      chk("b2_run2", run_at(2), 4);
      chk("b2_gap", gap_after(0), 9);
      chk("b2_pkt_pulses", pkt_pulses - base, 1);
      // 1024 idle cycles start one after the last read, then DRAIN, then PKTEND
      chk("b2_pkt_latency", pkt_cyc - last_wr_cyc, 1023);
      chk("b2_words", words, 28);
      chk("b2_pkt_cnt", pkt_cnt, 1);
`else
      push(24);
      run(300);
      chk("b2_run0", run_at(0), 8);
      chk("b2_run1", run_at(1), 8);
      chk("b2_run2", run_at(2), 8);
      chk("b2_gap", gap_after(0), 9);
      chk("b2_pkt_pulses", pkt_pulses - base, 0);
      chk("b2_words_wrap", words, 0);
      chk("b2_pkt_cnt", pkt_cnt, 0);
`endif

      // FIFO runs dry after 3 words, refill 10+ cycles later resumes the same burst
      clear_runs();
      base = pkt_pulses;
      push(3);
      run(14);
      push(6);
      run(60);
      chk("res_run0", run_at(0), 3);
      chk("res_run1", run_at(1), 5);
      chk("res_gap_full", gap_after(1), 9);
      chk("res_no_pkt", pkt_pulses - base, 0);
`ifdef DP23_GPIF_TX_PKTEND_EN
      run(1100);
      chk("res_pkt_pulses", pkt_pulses - base, 1);
      chk("res_pkt_cnt", pkt_cnt, 2);
      chk("res_words_wrap", words, 5);
`else
      run(5000);
      chk("stuck_pkt_pulses", pkt_pulses - base, 0);
      chk("stuck_pktend_n", pktend_n, 1);
      chk("stuck_state", dut.state_q, 1);
      chk("stuck_pkt_cnt", pkt_cnt, 0);
      push(7);
      run(40);
      chk("stuck_words", words, 16);
`endif
      chk("sb_drained", sb_q.size(), 0);

      // counter clear coincident with a write
      push(8);
      n = 0;
      while (wr_n && n < 20) begin
         tick();
         n++;
      end
      chk("clr_saw_write", wr_n, 0);
      rst_cnt = 1'b1;
      tick();
      rst_cnt = 1'b0;
      chk("clr_wins", words, 0);
      chk("clr_pkt_cnt", pkt_cnt, 0);
      run(30);
      chk("clr_words_after", words, 7);

      // reset with two reads in flight
      push(4);
      base = rd_seen;
      n = 0;
      while (rd_seen - base < 2 && n < 20) begin
         tick();
         n++;
      end
      chk("inflight_rd", rd_seen - base, 2);
      rst = 1'b1;
      base = wr_seen;
      tick();
      chk("mid_rst_rd", rd, 0);
      chk("mid_rst_wr_n", wr_n, 1);
      chk("mid_rst_pktend_n", pktend_n, 1);
      chk("mid_rst_data", data, 0);
      chk("mid_rst_words", words, 0);
      chk("mid_rst_pkt_cnt", pkt_cnt, 0);
      fifo_q.delete();
      sb_q.delete();
      p1 = 32'hDEAD_BEEF;
      p2 = 32'hDEAD_BEEF;
      empty = 1'b1;
      tick();
      rst = 1'b0;
      run(20);
      chk("mid_rst_no_slwr", wr_seen - base, 0);

      chk("rd_while_empty", rd_empty_viol, 0);
      chk("pktend_width", pkt_wide, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
